sprite_pack: RTL

- Serial-to-parallel packer for 2-bit sprite pixels; the write-side counterpart of the sprite row shifter.
- Accepts one pixel per clock over a valid/ready handshake and assembles 16 pixels into a 32-bit sprite word.
- Emits each word on a valid/ready output toward sprite memory.
- Supports flushing a partial word with zero (transparent) padding.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_pack_outreg.sv | 38 +++
 rtl/sprite_pack.sv | 101 ++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared sizing, pixel type and FSM states for the sprite pixel packer.
package sprite_pkg;
   localparam int PIX_W        = 2;
   localparam int PIX_PER_WORD = 16;
   localparam int WORD_W       = PIX_W * PIX_PER_WORD;
   localparam int IDX_W        = $clog2(PIX_PER_WORD);
   localparam int NPIX_W       = IDX_W + 1;

   typedef logic [PIX_W-1:0] pixel_t;

   localparam pixel_t PIX_TRANSPARENT = 2'b00;

   typedef enum logic {
      FILL,
      FLUSH_PEND
   } state_t;
endpackage

// File: rtl/sprite_pack_outreg.sv
// Single-entry holding register for a packed word plus its partial flag and pixel count.
// Reloads in the same cycle it drains; busy while holding a word downstream has not taken.
module sprite_pack_outreg
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] ld_data,
   input  logic              ld_partial,
   input  logic [NPIX_W-1:0] ld_npix,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              out_partial,
   output logic [NPIX_W-1:0] out_npix,
   output logic              drain,
   output logic              busy
);
   assign drain = out_valid & out_ready;
   assign busy  = out_valid & ~out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_partial <= 1'b0;
         out_npix    <= '0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_data    <= ld_data;
         out_partial <= ld_partial;
         out_npix    <= ld_npix;
      end else if (drain) begin
         out_valid   <= 1'b0;
      end
   end
endmodule

// File: rtl/sprite_pack.sv
// Packs 2-bit sprite pixels, first pixel in the low bits, into 32-bit words; 1 cycle from last accept to word_valid.
// pix_ready stalls only when the 16th pixel would find the output register still held, or while a flush waits.
module sprite_pack
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_in,
   output logic              pix_ready,
   input  logic              flush,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data,
   output logic              word_partial,
   output logic [NPIX_W-1:0] word_npix,
   input  logic              word_ready,
   output logic [15:0]       word_count
);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PIX_PER_WORD - 1);
   localparam logic [WORD_W-1:0] EMPTY    = {PIX_PER_WORD{PIX_TRANSPARENT}};

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [WORD_W-1:0]  acc, acc_nxt, acc_w;
   logic [NPIX_W-1:0]  held;
   logic               accept, last, out_busy, out_drain, load, ld_partial;

   assign last      = (idx == IDX_LAST);
   assign pix_ready = ~reset & (state == FILL) & ~(last & out_busy);
   assign accept    = pix_valid & pix_ready;
   assign held      = {1'b0, idx} + NPIX_W'(accept);

   // Accumulator including this cycle's pixel, so a same-cycle flush captures it.
   always_comb begin
      acc_w = acc;
      if (accept) acc_w[int'(idx)*PIX_W +: PIX_W] = pix_in;
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      acc_nxt    = acc_w;
      load       = 1'b0;
      ld_partial = 1'b0;
      if (state == FILL) begin
         if (accept && last) begin
            load    = 1'b1;
            idx_nxt = '0;
            acc_nxt = EMPTY;
         end else begin
            if (accept) idx_nxt = idx + 1'b1;
            if (flush && held != '0) begin
               if (!out_busy) begin
                  load       = 1'b1;
                  ld_partial = 1'b1;
                  idx_nxt    = '0;
                  acc_nxt    = EMPTY;
               end else begin
                  state_nxt = FLUSH_PEND;
               end
            end
         end
      end else if (out_drain) begin
         load       = 1'b1;
         ld_partial = 1'b1;
         idx_nxt    = '0;
         acc_nxt    = EMPTY;
         state_nxt  = FILL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FILL;
         idx        <= '0;
         acc        <= EMPTY;
         word_count <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         acc   <= acc_nxt;
         if (out_drain) word_count <= word_count + 16'd1;
      end
   end

   sprite_pack_outreg u_outreg (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .ld_data     (acc_w),
      .ld_partial  (ld_partial),
      .ld_npix     (held),
      .out_ready   (word_ready),
      .out_valid   (word_valid),
      .out_data    (word_data),
      .out_partial (word_partial),
      .out_npix    (word_npix),
      .drain       (out_drain),
      .busy        (out_busy)
   );
endmodule
